// File: rtl/ahb_timer_mc.sv
// ahb_timer_mc: AHB-Lite multi-channel timer slave.
//   One shared prescaler feeds NCH independent up-counters. Each channel
//   runs periodic or one-shot, raises a pending flag on compare and drives
//   an interrupt when its pending flag and interrupt enable are both set.
// Ports:
//   hclk, hresetn          clock, asynchronous active-low reset
//   hsel_i .. hwdata_i     AHB-Lite slave inputs (hburst_i ignored)
//   hreadyout_o, hresp_o   slave ready / response (two-cycle ERROR)
//   hrdata_o               read data, combinational in the data phase
//   timer_irq_o            per-channel interrupt (pend & ie)
//   timer_irq_any_o        OR of all channel interrupts
// Register map (offset = haddr[11:0]):
//   0x000 PSC, 0x004 PEND (W1C), 0x100+0x10*n CTRL{oneshot,ie,en},
//   +0x4 RELOAD, +0x8 COUNT (RO).
module ahb_timer_mc #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int NCH    = 4,
    parameter int PSC_W  = 16
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hsel_i,
    input  logic              hwrite_i,
    input  logic              hready_i,
    input  logic [2:0]        hsize_i,
    input  logic [2:0]        hburst_i,
    input  logic [1:0]        htrans_i,
    input  logic [AWIDTH-1:0] haddr_i,
    input  logic [DWIDTH-1:0] hwdata_i,
    output logic              hreadyout_o,
    output logic              hresp_o,
    output logic [DWIDTH-1:0] hrdata_o,
    output logic [NCH-1:0]    timer_irq_o,
    output logic              timer_irq_any_o
);

    localparam int unsigned NCH_U = NCH;

    typedef enum logic [1:0] {
        ST_OKAY,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t state, state_next;

    logic              unused_inputs;
    logic              accept;
    logic              ap_err;

    logic              dp_valid;
    logic              dp_write;
    logic              dp_err;
    logic [11:0]       dp_off;

    logic              wr;
    logic              rd;
    logic              wr_psc;
    logic              wr_pend;
    logic [NCH-1:0]    sel_ch;
    logic [NCH-1:0]    wr_ctrl;
    logic [NCH-1:0]    wr_reload;

    logic [PSC_W-1:0]  psc;
    logic [PSC_W-1:0]  psc_cnt;
    logic              any_en;
    logic              tick;

    logic [NCH-1:0]    pend;
    logic [NCH-1:0]    pend_set;
    logic [NCH-1:0]    pend_clr;
    logic [NCH-1:0]    en;
    logic [NCH-1:0]    ie;
    logic [NCH-1:0]    oneshot;
    logic [31:0]       reload [NCH];
    logic [31:0]       count  [NCH];

    assign unused_inputs = ^{hburst_i, htrans_i[0], haddr_i[AWIDTH-1:12]};

    // Offsets that decode to a register: PSC, PEND, or CTRL/RELOAD/COUNT
    // of an existing channel (channel slot +0xC is a hole).
    function automatic logic mapped(input logic [11:0] off);
        logic ok;
        ok = 1'b0;
        if (off == 12'h000 || off == 12'h004) begin
            ok = 1'b1;
        end else if (off[11:8] == 4'h1 && {28'd0, off[7:4]} < NCH_U &&
                     off[1:0] == 2'b00 && off[3:2] != 2'b11) begin
            ok = 1'b1;
        end
        return ok;
    endfunction

    assign accept = hsel_i & hready_i & htrans_i[1];
    assign ap_err = ~mapped(haddr_i[11:0]) | (hsize_i != 3'b010);

    // Address-phase capture; the error decision is taken here so the data
    // phase only needs to suppress the access.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_err   <= 1'b0;
            dp_off   <= '0;
        end else begin
            dp_valid <= accept;
            if (accept) begin
                dp_write <= hwrite_i;
                dp_err   <= ap_err;
                dp_off   <= haddr_i[11:0];
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state <= ST_OKAY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        hreadyout_o = 1'b1;
        hresp_o     = 1'b0;
        case (state)
            ST_OKAY: begin
                if (accept && ap_err) state_next = ST_ERR1;
            end
            ST_ERR1: begin
                hreadyout_o = 1'b0;
                hresp_o     = 1'b1;
                state_next  = ST_ERR2;
            end
            ST_ERR2: begin
                hresp_o    = 1'b1;
                state_next = (accept && ap_err) ? ST_ERR1 : ST_OKAY;
            end
            default: state_next = ST_OKAY;
        endcase
    end

    assign wr      = dp_valid & dp_write & ~dp_err;
    assign rd      = dp_valid & ~dp_write & ~dp_err;
    assign wr_psc  = wr & (dp_off == 12'h000);
    assign wr_pend = wr & (dp_off == 12'h004);

    always_comb begin
        sel_ch    = '0;
        wr_ctrl   = '0;
        wr_reload = '0;
        for (int unsigned n = 0; n < NCH_U; n++) begin
            sel_ch[n]    = (dp_off[11:8] == 4'h1) && (dp_off[7:4] == n[3:0]);
            wr_ctrl[n]   = wr & sel_ch[n] & (dp_off[3:0] == 4'h0);
            wr_reload[n] = wr & sel_ch[n] & (dp_off[3:0] == 4'h4);
        end
    end

    assign any_en = |en;
    assign tick   = any_en && (psc_cnt == psc);

    always_comb begin
        pend_set = '0;
        for (int unsigned n = 0; n < NCH_U; n++) begin
            pend_set[n] = en[n] & tick & (count[n] == reload[n]);
        end
        pend_clr = wr_pend ? hwdata_i[NCH-1:0] : '0;
    end

    // Channel state. Later assignments in this block take priority, so a
    // CTRL write overrides the one-shot auto-disable on the same edge.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            psc     <= '0;
            psc_cnt <= '0;
            pend    <= '0;
            en      <= '0;
            ie      <= '0;
            oneshot <= '0;
            for (int unsigned n = 0; n < NCH_U; n++) begin
                reload[n] <= '0;
                count[n]  <= '0;
            end
        end else begin
            if (wr_psc) psc <= hwdata_i[PSC_W-1:0];

            // No reset of psc_cnt on a PSC write: a lower PSC lets the
            // counter run on and wrap before the next tick.
            if (!any_en || tick) begin
                psc_cnt <= '0;
            end else begin
                psc_cnt <= psc_cnt + PSC_W'(1);
            end

            pend <= (pend & ~pend_clr) | pend_set;

            for (int unsigned n = 0; n < NCH_U; n++) begin
                if (!en[n]) begin
                    count[n] <= '0;
                end else if (tick) begin
                    if (count[n] == reload[n]) begin
                        count[n] <= '0;
                        if (oneshot[n]) en[n] <= 1'b0;
                    end else begin
                        count[n] <= count[n] + 32'd1;
                    end
                end
                if (wr_ctrl[n]) begin
                    en[n]      <= hwdata_i[0];
                    ie[n]      <= hwdata_i[1];
                    oneshot[n] <= hwdata_i[2];
                end
                if (wr_reload[n]) reload[n] <= hwdata_i[31:0];
            end
        end
    end

    always_comb begin
        hrdata_o = '0;
        if (rd) begin
            if (dp_off == 12'h000) begin
                hrdata_o[PSC_W-1:0] = psc;
            end else if (dp_off == 12'h004) begin
                hrdata_o[NCH-1:0] = pend;
            end else begin
                for (int unsigned n = 0; n < NCH_U; n++) begin
                    if (sel_ch[n]) begin
                        case (dp_off[3:0])
                            4'h0:    hrdata_o[2:0] = {oneshot[n], ie[n], en[n]};
                            4'h4:    hrdata_o      = reload[n];
                            4'h8:    hrdata_o      = count[n];
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign timer_irq_o     = pend & ie;
    assign timer_irq_any_o = |timer_irq_o;

endmodule

// File: doc/ahb_timer_mc.md
Name: ahb_timer_mc

Overview:
Multi-channel AHB-Lite timer slave with a shared programmable prescaler and NCH independent up-counters.
- Each channel runs in periodic or one-shot mode and has its own pending flag and interrupt output.
- Sits on the peripheral AHB segment next to the other perips and feeds the interrupt controller.
- Unsupported accesses get a proper two-cycle AHB ERROR response.

Parameters:
AWIDTH, 32, address bus width
DWIDTH, 32, data bus width (fixed 32; other values unsupported)
NCH, 4, number of timer channels (1..8)
PSC_W, 16, prescaler register width

Ports:
hclk  in  1  clock
hresetn  in  1  reset, asynchronous, active-low
hsel_i  in  1  slave select
hwrite_i  in  1  1=write
hready_i  in  1  bus ready
hsize_i  in  3  transfer size
hburst_i  in  3  burst type (ignored)
htrans_i  in  2  transfer type
haddr_i  in  AWIDTH  address
hwdata_i  in  DWIDTH  write data (data phase)
hreadyout_o  out  1  slave ready
hresp_o  out  1  0=OKAY, 1=ERROR
hrdata_o  out  DWIDTH  read data
timer_irq_o  out  NCH  per-channel irq = pend[n] & ie[n]
timer_irq_any_o  out  1  OR of timer_irq_o

Behaviour:
Reset values:
- All registers 0.
- hreadyout_o=1, hresp_o=0, hrdata_o=0, irqs 0.

Address phase:
- Accepted when hsel_i & hready_i & htrans_i[1].
- Latch addr[11:0], hwrite, and valid=1; otherwise valid=0 at that edge.

Decode (offset = haddr[11:0]):
- 0x000 PSC [PSC_W-1:0], RW.
- 0x004 PEND [NCH-1:0], RO; write 1 clears the bit.
- 0x100+0x10*n CTRL, RW: [0] en, [1] ie, [2] oneshot.
- +0x4 RELOAD, RW.
- +0x8 COUNT, RO; writes are ignored with OKAY.
- Unread bits return 0.

Error conditions:
- Unmapped offset, channel index >= NCH, or hsize_i != 3'b010 is an error transfer.

Slave FSM:
- States: OKAY, ERR1, ERR2.
- OKAY: hreadyout=1, hresp=0. An accepted error transfer goes to ERR1 on the next edge.
- ERR1: hreadyout=0, hresp=1; goes to ERR2.
- ERR2: hreadyout=1, hresp=1; goes to OKAY. A new transfer may be accepted in this cycle.
- An error transfer never modifies state.

Writes:
- Zero wait states.
- Registers update at the end of the data phase (edge after hwdata_i valid).

Reads:
- Zero wait states.
- hrdata_o is combinational from the latched address, valid in the data phase.
- hrdata_o is 0 when there is no valid read.

Prescaler:
- psc_cnt runs only while any en=1; otherwise it is held at 0.
- tick=1 when psc_cnt==PSC, then psc_cnt<=0; else psc_cnt++.
- PSC=0 gives a tick every cycle.
- A PSC write does not reset psc_cnt. If psc_cnt > new PSC, it wraps at 2^PSC_W.

Channel n:
- en=0: COUNT held at 0.
- en=1 on tick:
  - If COUNT==RELOAD: COUNT<=0 and pend[n]<=1. If oneshot=1, en<=0 in the same edge.
  - Otherwise COUNT++.
- Period is (RELOAD+1) ticks. RELOAD=0 sets pend every tick.
- A RELOAD write takes effect on the next compare.
- If RELOAD is written below the current COUNT, the count wraps through 2^32 before matching.

Simultaneous events:
- Hardware pend set and a W1C in the same cycle: set wins.
- Bus write of CTRL.en and a one-shot auto-clear in the same cycle: bus write wins.
- Channels are fully independent; several pend bits may set in the same cycle.
- Reset asserted mid-transfer or mid-count: immediate return to reset values, FSM to OKAY.

Test Plan:
- Write PSC=0, ch0 RELOAD=3, CTRL=0x3 (periodic) -> pend[0] sets every 4 cycles; timer_irq_o[0]=1; COUNT sequence reads 0,1,2,3,0.
- PSC=2, ch1 RELOAD=1, CTRL=0x7 (one-shot) -> pend[1] sets once after 6 cycles; CTRL reads 0x6; COUNT stays 0.
- Write PEND=0x1 in the same cycle as a ch0 compare -> pend[0] remains 1; a W1C on a later cycle clears it and irq drops.
- Read offset 0x0FC, write hsize=byte to 0x000, access ch index NCH -> ERR1/ERR2 two-cycle ERROR each; PSC unchanged.
- Back-to-back write RELOAD then read RELOAD of ch2 (value 0xDEAD_BEEF) -> read returns 0xDEAD_BEEF with no wait states.
- hresetn pulsed low while ch0 counting and ERR1 active -> all outputs and registers 0 immediately; hreadyout_o=1.
